bht_controller: RTL and testbench

Branch history table controller that owns an array of 2-bit saturating predictor counters. Its jobs:
- Serve registered taken/not-taken lookups to the fetch stage.
- Apply resolved-branch feedback from the execute stage.
- Sequence a multi-cycle table flush.
- Maintain a saturating mispredict statistic.

It sits between IF, which issues lookups, and EX, which resolves branches. It replaces per-branch standalone counters with one shared, indexed resource.

---
 rtl/bp_pkg.sv | 17 +
 rtl/bht_ctr_next.sv | 19 +
 rtl/bht_controller.sv | 109 ++++++++++
 tb/tb_bht_controller.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared branch-predictor types: 2-bit saturating counter encoding and the
// BHT controller FSM state encoding.
package bp_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SC_SNT = 2'b00;
  localparam ctr_t SC_WNT = 2'b01;
  localparam ctr_t SC_WT  = 2'b10;
  localparam ctr_t SC_ST  = 2'b11;

  typedef enum logic {
    BHT_IDLE  = 1'b0,
    BHT_SWEEP = 1'b1
  } bht_state_e;

endpackage

// File: rtl/bht_ctr_next.sv
// Next-value function of a 2-bit saturating predictor counter.
import bp_pkg::*;

module bht_ctr_next (
  input  ctr_t ctr_i,
  input  logic taken_i,
  output ctr_t next_o
);

  always_comb begin
    next_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != SC_ST) next_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != SC_SNT) next_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/bht_controller.sv
// Branch history table: registered lookups, EX feedback updates with a
// write-first bypass, a one-entry-per-cycle flush sweep and a mispredict count.
import bp_pkg::*;

module bht_controller #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lookup_valid,
  input  logic [IDX_W-1:0] lookup_index,
  output logic             pred_valid,
  output logic             pred_taken,
  input  logic             fb_valid,
  input  logic [IDX_W-1:0] fb_index,
  input  logic             fb_taken,
  input  logic             fb_mispredict,
  input  logic             flush,
  output logic             busy,
  output logic [CNT_W-1:0] mispredict_count,
  output bht_state_e       dbg_state
);

  bht_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  ctr_t             table_q [ENTRIES];
  ctr_t             table_d [ENTRIES];
  logic             pv_q, pv_d;
  logic             pt_q, pt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctr_t             fb_next;

  // One next-value instance feeds both the array write and the lookup bypass.
  bht_ctr_next u_ctr_next (
    .ctr_i   (table_q[fb_index]),
    .taken_i (fb_taken),
    .next_o  (fb_next)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    table_d = table_q;
    pv_d    = lookup_valid;
    pt_d    = pt_q;
    cnt_d   = cnt_q;

    if (fb_valid && fb_mispredict && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);

    case (state_q)
      BHT_IDLE: begin
        if (lookup_valid) begin
          if (fb_valid && (fb_index == lookup_index)) pt_d = fb_next[1];
          else                                        pt_d = table_q[lookup_index][1];
        end
        if (fb_valid) table_d[fb_index] = fb_next;
        if (flush) begin
          state_d = BHT_SWEEP;
          ptr_d   = '0;
        end
      end
      BHT_SWEEP: begin
        // The table is in transition, so every prediction is a safe not-taken.
        if (lookup_valid) pt_d = 1'b0;
        table_d[ptr_q] = SC_WNT;
        if (flush) begin
          ptr_d = '0;
        end else if (ptr_q == IDX_W'(ENTRIES - 1)) begin
          state_d = BHT_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = BHT_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BHT_IDLE;
      ptr_q   <= '0;
      pv_q    <= 1'b0;
      pt_q    <= 1'b0;
      cnt_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= SC_WNT;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pv_q    <= pv_d;
      pt_q    <= pt_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= table_d[i];
    end
  end

  assign pred_valid       = pv_q;
  assign pred_taken       = pt_q;
  assign busy             = (state_q == BHT_SWEEP);
  assign mispredict_count = cnt_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_bht_controller.sv
// Directed bench for bht_controller with a table-level reference model.
module tb_bht_controller;
  import bp_pkg::*;

  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             lookup_valid = 1'b0;
  logic [IDX_W-1:0] lookup_index = '0;
  logic             pred_valid;
  logic             pred_taken;
  logic             fb_valid = 1'b0;
  logic [IDX_W-1:0] fb_index = '0;
  logic             fb_taken = 1'b0;
  logic             fb_mispredict = 1'b0;
  logic             flush = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] mispredict_count;
  bht_state_e       dbg_state;

  bht_controller #(.ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .lookup_valid     (lookup_valid),
    .lookup_index     (lookup_index),
    .pred_valid       (pred_valid),
    .pred_taken       (pred_taken),
    .fb_valid         (fb_valid),
    .fb_index         (fb_index),
    .fb_taken         (fb_taken),
    .fb_mispredict    (fb_mispredict),
    .flush            (flush),
    .busy             (busy),
    .mispredict_count (mispredict_count),
    .dbg_state        (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_tbl [ENTRIES];
  int         m_sweep_left;
  int         m_cnt;
  int         m_pv;
  int         m_pt;
  int         m_look;
  logic [0:0] exp_q[$];

  function automatic int sat(input int v, input logic taken);
    if (taken) return (v < 3) ? v + 1 : 3;
    return (v > 0) ? v - 1 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) m_tbl[i] = 1;
      m_sweep_left = 0;
      m_cnt = 0;
      m_pv = 0;
      m_pt = 0;
      exp_q.delete();
    end else begin
      m_pv = lookup_valid;
      if (lookup_valid) begin
        if (m_sweep_left > 0) begin
          m_pt = 0;
        end else begin
          m_look = m_tbl[lookup_index];
          if (fb_valid && fb_index == lookup_index) m_look = sat(m_look, fb_taken);
          m_pt = m_look / 2;
        end
        exp_q.push_back(m_pt[0:0]);
      end
      if (m_sweep_left > 0) begin
        m_tbl[ENTRIES - m_sweep_left] = 1;
        m_sweep_left--;
      end else if (fb_valid) begin
        m_tbl[fb_index] = sat(m_tbl[fb_index], fb_taken);
      end
      if (flush) m_sweep_left = ENTRIES;
      if (fb_valid && fb_mispredict && m_cnt < CNT_MAX) m_cnt++;
    end
  end

  // ---------------- scoreboard compare ----------------
  logic [0:0] e;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("pred_valid", pred_valid, m_pv);
      if (m_pv) begin
        if (exp_q.size() == 0) chk("pred_queue_empty", 0, 1);
        else begin
          e = exp_q.pop_front();
          chk("pred_taken", pred_taken, e);
        end
      end else begin
        chk("pred_taken_hold", pred_taken, m_pt);
      end
      chk("busy", busy, (m_sweep_left > 0) ? 1 : 0);
      chk("dbg_state", (dbg_state == BHT_SWEEP) ? 1 : 0, (m_sweep_left > 0) ? 1 : 0);
      chk("mispredict_count", mispredict_count, m_cnt);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic lv, input int li, input logic fv, input int fi,
                     input logic ft, input logic fm, input logic fl);
    lookup_valid  = lv;
    lookup_index  = li[IDX_W-1:0];
    fb_valid      = fv;
    fb_index      = fi[IDX_W-1:0];
    fb_taken      = ft;
    fb_mispredict = fm;
    flush         = fl;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic look(input int i);
    cyc(1'b1, i, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic fb(input int i, input logic t, input logic m);
    cyc(1'b0, 0, 1'b1, i, t, m, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  int n;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_pred_valid", pred_valid, 0);
    chk("rst_pred_taken", pred_taken, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", mispredict_count, 0);
    rst_n = 1'b1;

    look(3);
    chk("lookup3_valid", pred_valid, 1);
    chk("lookup3_taken", pred_taken, 0);
    idle();
    chk("idle_valid", pred_valid, 0);

    fb(5, 1'b1, 1'b0); fb(5, 1'b1, 1'b0);
    look(5); chk("idx5_two_taken", pred_taken, 1);
    fb(5, 1'b1, 1'b0); fb(5, 1'b0, 1'b0);
    look(5); chk("idx5_hold_strong_taken", pred_taken, 1);
    repeat (4) fb(5, 1'b0, 1'b0);
    look(5); chk("idx5_hold_strong_not_taken", pred_taken, 0);
    fb(5, 1'b1, 1'b0); fb(5, 1'b1, 1'b0);
    look(5); chk("idx5_recover", pred_taken, 1);

    cyc(1'b1, 7, 1'b1, 7, 1'b1, 1'b1, 1'b0);
    chk("bypass_idx7", pred_taken, 1);
    look(6); chk("idx6_untouched", pred_taken, 0);
    look(7); chk("idx7_written", pred_taken, 1);
    chk("count_one", mispredict_count, 1);

    for (int i = 0; i < 3; i++) begin
      fb(i, 1'b1, 1'b0); fb(i, 1'b1, 1'b0);
    end
    look(0); chk("idx0_strong", pred_taken, 1);

    // flush with a coincident IDLE update and lookup on index 0
    cyc(1'b1, 0, 1'b1, 0, 1'b1, 1'b0, 1'b1);
    chk("flush_cycle_lookup", pred_taken, 1);
    n = 0;
    while (busy && n < 40) begin
      cyc(1'b1, n % ENTRIES, 1'b1, 9, 1'b1, 1'b0, 1'b0);
      n++;
    end
    chk("busy_len_first", n, ENTRIES);
    for (int i = 0; i < ENTRIES; i++) begin
      look(i);
      chk("post_flush_entry", pred_taken, 0);
    end

    cyc(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    repeat (4) idle();
    cyc(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (busy && n < 40) begin
      idle();
      n++;
    end
    chk("busy_len_reflush", n, ENTRIES);

    for (int i = 0; i < 20; i++) fb(i % ENTRIES, i[0], 1'b1);
    idle();
    chk("count_saturated", mispredict_count, CNT_MAX);
    fb(2, 1'b1, 1'b1);
    chk("count_held", mispredict_count, CNT_MAX);

    cyc(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    repeat (3) look(4);
    chk("sweep_busy_before_reset", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_count", mispredict_count, 0);
    chk("async_rst_pred_valid", pred_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    look(2);
    chk("after_reset_idx2", pred_taken, 0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
